instr_item_encoder: RTL
=======================

Name: instr_item_encoder

Overview:
- Converts decoded instruction items back into 32-bit RV32I machine words. Input fields match instruction_item_t: instruction, rs1, rs2, rd, imm. This is the inverse of the DUT decoder.
- Buffers the encoded words in a small FIFO and presents them on a valid/ready stream, each word tagged with its PC. The stream feeds the bench's instruction-memory model.
- Used by the testbench to turn randomized items into a program image.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- BASE_PC, 32'h0000_0000, PC of the first word after reset or flush.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input item valid.
- in_ready  out  1  FIFO can accept an item.
- in_instr  in  6  instruction_t code.
- in_rs1  in  5  source register 1.
- in_rs2  in  5  source register 2.
- in_rd  in  5  destination register.
- in_imm  in  WORD_SIZE  immediate, sign-extended, as in instruction_item_t.
- out_valid  out  1  head word valid.
- out_ready  in  1  consumer accepts the head word.
- out_word  out  32  encoded instruction.
- out_pc  out  WORD_SIZE  PC of out_word.
- out_err  out  1  the immediate was out of range for its type; the word is still emitted, with the immediate truncated.
- flush  in  1  synchronous clear plus PC reload.
- flush_pc  in  WORD_SIZE  PC loaded on flush.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async, rst_n=0): FIFO empty, level=0, in_ready=1, out_valid=0, out_word=0, out_pc=0, out_err=0, PC counter=BASE_PC.
- Encoding is combinational from the in_* fields. The encoded word, its error bit and the PC counter value are written into the FIFO on an input handshake (in_valid & in_ready). The PC counter then advances by 4 and wraps modulo 2^32.
- Latency: an item pushed in cycle N appears at the head (out_valid=1) in cycle N+1, provided the FIFO was empty.
- Output: out_* show the head entry whenever level>0. The head entry pops on out_valid & out_ready. out_* stay stable while out_valid=1 and out_ready=0.
- Full: in_ready = (level<DEPTH) or out_ready. Push and pop in the same cycle while full is legal; level stays unchanged.
- Empty: out_valid=0 and out_word holds its last value. A pop attempted while empty has no effect.
- Same-cycle push and pop with level=1: the new entry becomes the head next cycle; level stays 1.
- Flush (synchronous, highest priority):
  - empties the FIFO and loads the PC counter with flush_pc;
  - an input handshake in the same cycle is discarded;
  - out_valid=0 in the next cycle.
- Reset mid-stream: all contents are lost and the PC returns to BASE_PC.
- Encodings use the shared opcode/funct constants:
  - R: funct7|rs2|rs1|f3|rd|0110011; SUB and SRA use funct7 0100000.
  - I (arith): imm[11:0]|rs1|f3|rd|0010011.
  - SLLI/SRLI/SRAI: funct7|imm[4:0]|rs1|f3|rd|0010011.
  - I_L (loads): opcode 0000011. JALR: opcode 1100111.
  - S: imm[11:5]|rs2|rs1|f3|imm[4:0]|0100011.
  - B: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|1100011.
  - U: imm[31:12]|rd|opcode, with LUI 0110111 and AUIPC 0010111.
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|1101111.
  - NO_INST or any undefined code: 0x00000013 (NOP), out_err=0.
- out_err is set when any of these holds:
  - I, I_L, S: imm is not a signed 12-bit value.
  - Shifts: imm[31:5]≠0.
  - B: imm is not signed 13-bit, or imm[0]=1.
  - J: imm is not signed 21-bit, or imm[0]=1.
  - U: imm[11:0]≠0.
- Register fields unused by a type are ignored and encoded from the immediate as specified above.

Decomposition:
- Shared package holds:
  - the existing instruction_t and instruction_type_t;
  - opcode, funct3 and funct7 constants;
  - a new typedef enc_entry_t {logic [31:0] word; addr_t pc; logic err;};
  - a function mapping instruction_t to instruction_type_t.
- Sub-module rv32i_encode: purely combinational item→{word, err}.
- The parent holds the FIFO (pointers plus count), the PC counter and the handshakes.

Test Plan:
- Reset, then ADDI rd=1 rs1=0 imm=5 with out_ready=1 → next cycle: out_word=0x00500093, out_pc=0, out_err=0.
- ADD x3,x1,x2; SW x2,8(x1); BEQ x1,x2,-4 pushed back to back → words 0x002081B3, 0x0020A423, 0xFE208EE3 with out_pc 0, 4, 8.
- LUI x5 with imm 0x12345000 → 0x123452B7, out_err=0. ADDI imm=4096 → out_err=1 and imm field 0x000. BEQ imm=3 → out_err=1.
- DEPTH=4, out_ready=0, five items offered → in_ready falls after 4 handshakes and level=4. Then out_ready=1 with in_valid=1 → level holds at 4, and words drain in order.
- Flush with flush_pc=0x100 while level=3 and a push occurs in the same cycle → next cycle level=0, out_valid=0. The next push emits out_pc=0x100.
- Reset asserted mid-stream with level=2 → all outputs immediately reach their reset values. After release, the first push has out_pc=BASE_PC.

Source files
------------

// File: rtl/instr_item_encoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : instr_item_encoder_pkg
//  Description : Shared RV32I item types, opcode/funct constants, FIFO entry
//                type and the instruction -> format classifier.
//  Revision    : 1.0  initial release
// ============================================================================
package instr_item_encoder_pkg;

    localparam int WORD_SIZE = 32;
    typedef logic [WORD_SIZE-1:0] addr_t;

    // Decoded instruction codes as carried in instruction_item_t.
    // Codes 38..63 are undefined and encode as a NOP.
    typedef enum logic [5:0] {
        NO_INST = 6'd0,
        LUI     = 6'd1,  AUIPC = 6'd2,  JAL   = 6'd3,  JALR  = 6'd4,
        BEQ     = 6'd5,  BNE   = 6'd6,  BLT   = 6'd7,  BGE   = 6'd8,
        BLTU    = 6'd9,  BGEU  = 6'd10,
        LB      = 6'd11, LH    = 6'd12, LW    = 6'd13, LBU   = 6'd14,
        LHU     = 6'd15,
        SB      = 6'd16, SH    = 6'd17, SW    = 6'd18,
        ADDI    = 6'd19, SLTI  = 6'd20, SLTIU = 6'd21, XORI  = 6'd22,
        ORI     = 6'd23, ANDI  = 6'd24, SLLI  = 6'd25, SRLI  = 6'd26,
        SRAI    = 6'd27,
        ADD     = 6'd28, SUB   = 6'd29, SLL   = 6'd30, SLT   = 6'd31,
        SLTU    = 6'd32, XOR   = 6'd33, SRL   = 6'd34, SRA   = 6'd35,
        OR      = 6'd36, AND   = 6'd37
    } instruction_t;

    typedef enum logic [3:0] {
        T_NONE = 4'd0,
        T_R    = 4'd1,
        T_I    = 4'd2,
        T_I_SH = 4'd3,
        T_I_L  = 4'd4,
        T_JALR = 4'd5,
        T_S    = 4'd6,
        T_B    = 4'd7,
        T_U    = 4'd8,
        T_J    = 4'd9
    } instruction_type_t;

    // Major opcodes
    localparam logic [6:0] c_opc_op     = 7'b0110011;
    localparam logic [6:0] c_opc_opimm  = 7'b0010011;
    localparam logic [6:0] c_opc_load   = 7'b0000011;
    localparam logic [6:0] c_opc_jalr   = 7'b1100111;
    localparam logic [6:0] c_opc_store  = 7'b0100011;
    localparam logic [6:0] c_opc_branch = 7'b1100011;
    localparam logic [6:0] c_opc_lui    = 7'b0110111;
    localparam logic [6:0] c_opc_auipc  = 7'b0010111;
    localparam logic [6:0] c_opc_jal    = 7'b1101111;

    // funct7 variants
    localparam logic [6:0] c_f7_base = 7'b0000000;
    localparam logic [6:0] c_f7_alt  = 7'b0100000;

    // Canonical NOP (addi x0, x0, 0)
    localparam logic [31:0] c_nop_word = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] word;
        addr_t       pc;
        logic        err;
    } enc_entry_t;

    // Map an instruction code onto its encoding format.
    function automatic instruction_type_t get_type(input logic [5:0] code);
        instruction_type_t t;
        t = T_NONE;
        case (code)
            ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND: t = T_R;
            ADDI, SLTI, SLTIU, XORI, ORI, ANDI:              t = T_I;
            SLLI, SRLI, SRAI:                                t = T_I_SH;
            LB, LH, LW, LBU, LHU:                            t = T_I_L;
            JALR:                                            t = T_JALR;
            SB, SH, SW:                                      t = T_S;
            BEQ, BNE, BLT, BGE, BLTU, BGEU:                  t = T_B;
            LUI, AUIPC:                                      t = T_U;
            JAL:                                             t = T_J;
            default:                                         t = T_NONE;
        endcase
        return t;
    endfunction

    // funct3 field for every code that carries one.
    function automatic logic [2:0] get_funct3(input logic [5:0] code);
        logic [2:0] f;
        f = 3'b000;
        case (code)
            SLL, SLLI, BNE, LH, SH:        f = 3'b001;
            SLT, SLTI, LW, SW:             f = 3'b010;
            SLTU, SLTIU:                   f = 3'b011;
            XOR, XORI, BLT, LBU:           f = 3'b100;
            SRL, SRA, SRLI, SRAI, BGE, LHU: f = 3'b101;
            OR, ORI, BLTU:                 f = 3'b110;
            AND, ANDI, BGEU:               f = 3'b111;
            default:                       f = 3'b000;
        endcase
        return f;
    endfunction

    // SUB, SRA and SRAI use the alternate funct7.
    function automatic logic [6:0] get_funct7(input logic [5:0] code);
        logic [6:0] f;
        f = c_f7_base;
        if (code == SUB || code == SRA || code == SRAI) begin
            f = c_f7_alt;
        end
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_item_encoder_encode.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_encode
//  Description : Combinational RV32I encoder, decoded item -> machine word
//                plus an out-of-range immediate flag.
//  Revision    : 1.0  initial release
// ============================================================================
module rv32i_encode
    import instr_item_encoder_pkg::*;
(
    input  logic [5:0]           i_instr,
    input  logic [4:0]           i_rs1,
    input  logic [4:0]           i_rs2,
    input  logic [4:0]           i_rd,
    input  logic [WORD_SIZE-1:0] i_imm,
    output logic [31:0]          o_word,
    output logic                 o_err
);

    instruction_type_t w_type;
    logic [2:0]        w_f3;
    logic [6:0]        w_f7;
    logic              w_s12_ok;
    logic              w_s13_ok;
    logic              w_s21_ok;

    // Range checks: a value fits in N signed bits when bits [31:N-1] agree.
    assign w_s12_ok = (&i_imm[31:11]) | ~(|i_imm[31:11]);
    assign w_s13_ok = (&i_imm[31:12]) | ~(|i_imm[31:12]);
    assign w_s21_ok = (&i_imm[31:20]) | ~(|i_imm[31:20]);

    assign w_type = get_type(i_instr);
    assign w_f3   = get_funct3(i_instr);
    assign w_f7   = get_funct7(i_instr);

    // Assemble the word for the item's format; out-of-range immediates are truncated.
    always_comb begin
        o_word = c_nop_word;
        o_err  = 1'b0;
        case (w_type)
            T_R: begin
                o_word = {w_f7, i_rs2, i_rs1, w_f3, i_rd, c_opc_op};
            end
            T_I: begin
                o_word = {i_imm[11:0], i_rs1, w_f3, i_rd, c_opc_opimm};
                o_err  = ~w_s12_ok;
            end
            T_I_SH: begin
                o_word = {w_f7, i_imm[4:0], i_rs1, w_f3, i_rd, c_opc_opimm};
                o_err  = |i_imm[31:5];
            end
            T_I_L: begin
                o_word = {i_imm[11:0], i_rs1, w_f3, i_rd, c_opc_load};
                o_err  = ~w_s12_ok;
            end
            T_JALR: begin
                o_word = {i_imm[11:0], i_rs1, w_f3, i_rd, c_opc_jalr};
                o_err  = ~w_s12_ok;
            end
            T_S: begin
                o_word = {i_imm[11:5], i_rs2, i_rs1, w_f3, i_imm[4:0], c_opc_store};
                o_err  = ~w_s12_ok;
            end
            T_B: begin
                o_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, w_f3,
                          i_imm[4:1], i_imm[11], c_opc_branch};
                o_err  = ~w_s13_ok | i_imm[0];
            end
            T_U: begin
                o_word = {i_imm[31:12], i_rd,
                          (i_instr == LUI) ? c_opc_lui : c_opc_auipc};
                o_err  = |i_imm[11:0];
            end
            T_J: begin
                o_word = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12],
                          i_rd, c_opc_jal};
                o_err  = ~w_s21_ok | i_imm[0];
            end
            default: begin
                o_word = c_nop_word;
                o_err  = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/instr_item_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : instr_item_encoder
//  Description : Encodes decoded RV32I items into machine words, tags each
//                with a running PC and streams them out through a FIFO.
//  Revision    : 1.0  initial release
// ============================================================================
module instr_item_encoder
    import instr_item_encoder_pkg::*;
#(
    parameter int    DEPTH   = 4,
    parameter addr_t BASE_PC = 32'h0000_0000
)(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [5:0]                in_instr,
    input  logic [4:0]                in_rs1,
    input  logic [4:0]                in_rs2,
    input  logic [4:0]                in_rd,
    input  logic [WORD_SIZE-1:0]      in_imm,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [31:0]               out_word,
    output logic [WORD_SIZE-1:0]      out_pc,
    output logic                      out_err,
    input  logic                      flush,
    input  logic [WORD_SIZE-1:0]      flush_pc,
    output logic [$clog2(DEPTH):0]    level
);

    localparam int                 c_ptr_w = $clog2(DEPTH);
    localparam int                 c_lvl_w = c_ptr_w + 1;
    localparam logic [c_lvl_w-1:0] c_depth = c_lvl_w'(DEPTH);

    enc_entry_t           r_mem [DEPTH];
    enc_entry_t           r_last;
    enc_entry_t           w_entry;
    enc_entry_t           w_head;
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_lvl_w-1:0]   r_count;
    addr_t                r_pc;
    logic [31:0]          w_word;
    logic                 w_err;
    logic                 w_push;
    logic                 w_pop;

    rv32i_encode u_encode (
        .i_instr (in_instr),
        .i_rs1   (in_rs1),
        .i_rs2   (in_rs2),
        .i_rd    (in_rd),
        .i_imm   (in_imm),
        .o_word  (w_word),
        .o_err   (w_err)
    );

    assign w_entry = '{word: w_word, pc: r_pc, err: w_err};
    assign w_head  = r_mem[r_rd_ptr];

    // A full FIFO still accepts an item when the head leaves in the same cycle.
    assign in_ready  = (r_count < c_depth) | out_ready;
    assign out_valid = (r_count != '0);
    assign w_pop     = out_valid & out_ready;
    // Flush discards any item offered in the same cycle.
    assign w_push    = in_valid & in_ready & ~flush;

    // While empty the outputs keep showing the last entry that left the FIFO.
    assign out_word = out_valid ? w_head.word : r_last.word;
    assign out_pc   = out_valid ? w_head.pc   : r_last.pc;
    assign out_err  = out_valid ? w_head.err  : r_last.err;
    assign level    = r_count;

    // Storage array; only written on an accepted push, so no reset needed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    // Pointers, occupancy, PC counter and the held last-popped entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_pc     <= BASE_PC;
            r_last   <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_pc     <= flush_pc;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_pc     <= r_pc + 32'd4;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_last   <= w_head;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire
